dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (auxiliary master: DMA or debug loader).
- The memory has asynchronous read and synchronous write, so this block grants at most one access per cycle.
- The memory-side request is driven combinationally from the winning port. Read data is registered and returned one cycle later.
- A starvation counter keeps port 1 from being locked out by a busy core.

---
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (async read, sync write).
// Optional macro ARB_ROUND_ROBIN_EN swaps the starvation counter for round-robin priority.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic win1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_win;
    logic contested;

    assign contested = p0_req & p1_req;
    // last_win = 0 means port 0 won the last contested cycle, so port 1 has priority
    assign win1 = p1_req & (~p0_req | ~last_win);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win <= 1'b0;
        end else if (contested) begin
            last_win <= win1;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    assign win1 = p1_req & (~p0_req | (starve_cnt == STARVE_LIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (p1_gnt || !p1_req) begin
            starve_cnt <= 4'd0;
        end else if (p0_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    // Grants are gated by rst so nothing reaches the memory while in reset
    assign p1_gnt    = win1 & ~rst;
    assign p0_gnt    = p0_req & ~win1 & ~rst;
    assign mem_addr  = win1 ? p1_addr : p0_addr;
    assign mem_wdata = win1 ? p1_wdata : p0_wdata;
    assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model and a read-response scoreboard.
// Handles both the default build and ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:15];

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    endtask

    task automatic check_gnt(input string tag, input logic g0, input logic g1);
        check({tag, "_p0_gnt"}, p0_gnt, g0);
        check({tag, "_p1_gnt"}, p1_gnt, g1);
    endtask

    // Advance one clock and compare any read response due this cycle.
    task automatic tick();
        resp_t r;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check("rvalid_p0", p0_rvalid, r.port == 1'b0);
            check("rvalid_p1", p1_rvalid, r.port == 1'b1);
            check("rdata", r.port ? p1_rdata : p0_rdata, r.data);
        end else begin
            check("idle_rvalid_p0", p0_rvalid, 1'b0);
            check("idle_rvalid_p1", p1_rvalid, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first1, exp1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        rst = 1'b1;
        set_p0(1'b1, 1'b1, 32'h10, 32'hBAD0BAD0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state with a request present
        #2;
        check_gnt("rst", 1'b0, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_p0_rvalid", p0_rvalid, 1'b0);
        check("rst_p1_rvalid", p1_rvalid, 1'b0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        @(posedge clk); #1;
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_write_suppressed", mem[4], 32'hDEADBEEF);

        // Single p0 read
        set_p0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check_gnt("rd0", 1'b1, 1'b0);
        check("rd0_mem_we", mem_we, 1'b0);
        check("rd0_mem_addr", mem_addr, 32'h10);
        sb.push_back('{1'b0, 32'hDEADBEEF});
        tick();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);

        // p1 write then p0 read back
        set_p1(1'b1, 1'b1, 32'h20, 32'h12345678);
        #1;
        check_gnt("wr1", 1'b0, 1'b1);
        check("wr1_mem_we", mem_we, 1'b1);
        check("wr1_mem_addr", mem_addr, 32'h20);
        check("wr1_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        set_p1(1'b0, 1'b0, 32'h0, 32'h0);
        set_p0(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        check_gnt("rd20", 1'b1, 1'b0);
        check("rd20_mem_we", mem_we, 1'b0);
        sb.push_back('{1'b0, 32'h12345678});
        tick();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_gnt("idle", 1'b0, 1'b0);
        check("idle_mem_we", mem_we, 1'b0);
        tick();

        // Contested reads: loser holds and is served next cycle
`ifdef ARB_ROUND_ROBIN_EN
        first1 = 1'b1;
`else
        first1 = 1'b0;
`endif
        set_p0(1'b1, 1'b0, 32'h10, 32'h0);
        set_p1(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        check_gnt("cont_a", !first1, first1);
        sb.push_back(first1 ? resp_t'{1'b1, 32'h12345678} : resp_t'{1'b0, 32'hDEADBEEF});
        tick();
        if (first1) set_p1(1'b0, 1'b0, 32'h0, 32'h0);
        else        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_gnt("cont_b", first1, !first1);
        sb.push_back(first1 ? resp_t'{1'b0, 32'hDEADBEEF} : resp_t'{1'b1, 32'h12345678});
        tick();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("p0_rdata_hold", p0_rdata, 32'hDEADBEEF);
        check("p1_rdata_hold", p1_rdata, 32'h12345678);

        // Both writing continuously for 12 cycles
        set_p0(1'b1, 1'b1, 32'h30, 32'hA0A0A0A0);
        set_p1(1'b1, 1'b1, 32'h34, 32'hB1B1B1B1);
        for (int i = 0; i < 12; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = (i % 5) == 4;
`endif
            #1;
            check($sformatf("starve_%0d", i), {p0_gnt, p1_gnt}, {!exp1, exp1});
            check($sformatf("starve_we_%0d", i), mem_we, 1'b1);
            tick();
        end

        // p0 read granted while p1 waits, then reset the following cycle
        set_p0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check_gnt("pre_rst", 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_p0(1'b1, 1'b1, 32'h10, 32'hBAD0BAD0);
        #1;
        check("midrst_p0_rvalid", p0_rvalid, 1'b0);
        check("midrst_p0_rdata", p0_rdata, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check_gnt($sformatf("midrst_%0d", i), 1'b0, 1'b0);
            check($sformatf("midrst_we_%0d", i), mem_we, 1'b0);
            tick();
        end
        rst = 1'b0;
        check("midrst_write_suppressed", mem[4], 32'hDEADBEEF);

        // After reset the priority state starts fresh
        set_p0(1'b1, 1'b1, 32'h38, 32'hC2C2C2C2);
        set_p1(1'b1, 1'b1, 32'h3C, 32'hD3D3D3D3);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp1 = (i % 2) == 0;
`else
            exp1 = (i % 5) == 4;
`endif
            #1;
            check($sformatf("post_rst_%0d", i), {p0_gnt, p1_gnt}, {!exp1, exp1});
            tick();
        end
        set_p1(1'b0, 1'b0, 32'h0, 32'h0);
        set_p0(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check_gnt("final_rd", 1'b1, 1'b0);
        sb.push_back('{1'b0, 32'hDEADBEEF});
        tick();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
